// File: rtl/column_move_collector.sv
// Gathers the move lists of one board column's squares into a local show-ahead column FIFO.
// Latency: one SCAN cycle per square selection, then one word per cycle while draining; FIFO head is visible the cycle after a push.
// Backpressure: square pops stall while the column FIFO is full and not being read this cycle; END words are always consumed.
module column_move_collector #(
    parameter int NSQ    = 8,
    parameter int MOVE_W = 48,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [2:0]                i_xpos,
    input  logic [NSQ-1:0]            i_sq_done,
    input  logic [NSQ-1:0]            i_sq_empty,
    input  logic [NSQ*MOVE_W-1:0]     i_sq_data,
    output logic [NSQ-1:0]            o_sq_rden,
    input  logic                      i_out_rden,
    output logic [MOVE_W-1:0]         o_out_data,
    output logic                      o_out_empty,
    output logic [$clog2(DEPTH):0]    o_out_count,
    output logic [CNT_W-1:0]          o_moves_total,
    output logic                      o_done,
    output logic                      o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NF = MOVE_W / 6;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [2:0]         r_ptr;
    logic [NSQ-1:0]     r_moved;

    logic [MOVE_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [CNT_W-1:0]   r_moves_total;
    logic               r_err;

    logic [MOVE_W-1:0]  w_cur;
    logic               w_cur_empty;
    logic               w_cur_done;
    logic               w_is_end;
    logic [5:0]         w_end_pat;
    logic               w_sel_found;
    logic [2:0]         w_sel_idx;
    logic               w_all_moved;
    logic               w_can_accept;
    logic               w_sq_pop;
    logic               w_push;
    logic               w_fifo_pop;
    logic               w_fifo_empty;

    // Mux out the selected square's head word and status bits.
    always_comb begin
        w_cur       = '0;
        w_cur_empty = 1'b1;
        w_cur_done  = 1'b0;
        for (int i = 0; i < NSQ; i++) begin
            if (3'(i) == r_ptr) begin
                w_cur       = i_sq_data[i*MOVE_W +: MOVE_W];
                w_cur_empty = i_sq_empty[i];
                w_cur_done  = i_sq_done[i];
            end
        end
    end

    // An END word names the selected square as both source and destination in every field.
    always_comb begin
        w_end_pat = {i_xpos, r_ptr};
        w_is_end  = 1'b1;
        for (int f = 0; f < NF; f++) begin
            if (w_cur[f*6 +: 6] != w_end_pat) begin
                w_is_end = 1'b0;
            end
        end
    end

    // Highest-index finished square that has not yet been drained wins the scan.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = 0; i < NSQ; i++) begin
            if (i_sq_done[i] && !r_moved[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = 3'(i);
            end
        end
    end

    assign w_all_moved  = &r_moved;
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_pop   = i_out_rden && !w_fifo_empty;
    // A full FIFO still takes a word when the reader frees a slot in the same cycle.
    assign w_can_accept = (r_count < FULL_CNT) || ((r_count == FULL_CNT) && i_out_rden);
    // A restart owns the cycle, so no square word is consumed alongside it.
    assign w_sq_pop     = (r_state == ST_DRAIN) && !i_start && !w_cur_empty &&
                          (w_is_end || w_can_accept);
    assign w_push       = w_sq_pop && !w_is_end;

    // Drive the one-hot pop strobe toward the square being drained.
    always_comb begin
        o_sq_rden = '0;
        for (int i = 0; i < NSQ; i++) begin
            o_sq_rden[i] = w_sq_pop && (3'(i) == r_ptr);
        end
    end

    // Next-state logic; a start pulse overrides whatever the current state wants.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  w_next_state = ST_IDLE;
            ST_SCAN: begin
                if (w_all_moved) begin
                    w_next_state = ST_DONE;
                end else if (w_sel_found) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_sq_pop && w_is_end) begin
                    w_next_state = ST_SCAN;
                end
            end
            ST_DONE:  w_next_state = ST_DONE;
            default:  w_next_state = ST_IDLE;
        endcase
        if (i_start) begin
            w_next_state = ST_SCAN;
        end
    end

    // State register, square pointer and per-square drained flags.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_moved <= '0;
        end else begin
            r_state <= w_next_state;
            if (i_start) begin
                r_moved <= '0;
            end else begin
                if ((r_state == ST_SCAN) && !w_all_moved && w_sel_found) begin
                    r_ptr <= w_sel_idx;
                end
                if (w_sq_pop && w_is_end) begin
                    for (int i = 0; i < NSQ; i++) begin
                        if (3'(i) == r_ptr) begin
                            r_moved[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Column FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_cur;
        end
    end

    // Column FIFO pointers and occupancy; start flushes everything.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_start) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_fifo_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_fifo_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of collected moves and the sticky error flag.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_moves_total <= '0;
            r_err         <= 1'b0;
        end else if (i_start) begin
            r_moves_total <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_push && (r_moves_total != '1)) begin
                r_moves_total <= r_moves_total + CNT_W'(1);
            end
            if ((i_out_rden && w_fifo_empty) ||
                ((r_state == ST_DRAIN) && !w_cur_done)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_out_data    = r_mem[r_rptr];
    assign o_out_empty   = w_fifo_empty;
    assign o_out_count   = r_count;
    assign o_moves_total = r_moves_total;
    assign o_done        = (r_state == ST_DONE);
    assign o_err         = r_err;

endmodule

// File: tb/tb_column_move_collector.sv
// Bench for column_move_collector: square FIFO models, column reader, scoreboard of expected moves.
// Expected output order is derived from the lists at start: squares high to low, each list in order.
// Reader either idles, reads randomly, or reads whenever the column FIFO is non-empty.
module tb_column_move_collector;

    localparam int NSQ    = 8;
    localparam int MOVE_W = 48;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic                   clk;
    logic                   i_reset;
    logic                   i_start;
    logic [2:0]             xpos;
    logic [NSQ-1:0]         i_sq_done;
    logic [NSQ-1:0]         i_sq_empty;
    logic [NSQ*MOVE_W-1:0]  i_sq_data;
    logic [NSQ-1:0]         o_sq_rden;
    logic                   i_out_rden;
    logic [MOVE_W-1:0]      o_out_data;
    logic                   o_out_empty;
    logic [$clog2(DEPTH):0] o_out_count;
    logic [CNT_W-1:0]       o_moves_total;
    logic                   o_done;
    logic                   o_err;

    column_move_collector #(
        .NSQ(NSQ), .MOVE_W(MOVE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_xpos(xpos),
        .i_sq_done(i_sq_done), .i_sq_empty(i_sq_empty), .i_sq_data(i_sq_data),
        .o_sq_rden(o_sq_rden), .i_out_rden(i_out_rden), .o_out_data(o_out_data),
        .o_out_empty(o_out_empty), .o_out_count(o_out_count),
        .o_moves_total(o_moves_total), .o_done(o_done), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [MOVE_W-1:0] sq_q [NSQ][$];
    logic [MOVE_W-1:0] exp_q [$];
    int                exp_total;
    logic [NSQ-1:0]    done_mask;
    logic [NSQ-1:0]    rd_snap;
    logic [NSQ-1:0]    empty_snap;
    int                stall_pct;
    int                rd_mode;   // 0 idle, 1 random, 2 whenever non-empty, 3 manual

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MOVE_W-1:0] end_word(input int sq);
        logic [MOVE_W-1:0] w;
        logic [2:0]        s;
        s = 3'(sq);
        for (int f = 0; f < MOVE_W / 6; f++) begin
            w[f*6 +: 6] = {xpos, s};
        end
        return w;
    endfunction

    function automatic logic [MOVE_W-1:0] rand_word();
        return {16'($urandom), $urandom};
    endfunction

    task automatic load_list(input int sq, input int n);
        logic [MOVE_W-1:0] w;
        sq_q[sq].delete();
        for (int k = 0; k < n; k++) begin
            w = rand_word();
            while (w == end_word(sq)) w = rand_word();
            sq_q[sq].push_back(w);
        end
        sq_q[sq].push_back(end_word(sq));
    endtask

    // Reference: all finished squares, highest index first, every word before its END in list order.
    task automatic build_expected();
        exp_q.delete();
        exp_total = 0;
        for (int sq = NSQ - 1; sq >= 0; sq--) begin
            if (done_mask[sq]) begin
                for (int k = 0; k < sq_q[sq].size() - 1; k++) begin
                    exp_q.push_back(sq_q[sq][k]);
                    exp_total++;
                end
            end
        end
    endtask

    task automatic drive_sq();
        logic [NSQ-1:0]        e;
        logic [NSQ*MOVE_W-1:0] d;
        for (int sq = 0; sq < NSQ; sq++) begin
            if (sq_q[sq].size() == 0 || $urandom_range(99) < stall_pct) begin
                e[sq] = 1'b1;
                d[sq*MOVE_W +: MOVE_W] = rand_word();
            end else begin
                e[sq] = 1'b0;
                d[sq*MOVE_W +: MOVE_W] = sq_q[sq][0];
            end
        end
        i_sq_empty = e;
        i_sq_data  = d;
    endtask

    always @(negedge clk) begin
        rd_snap    = o_sq_rden;
        empty_snap = i_sq_empty;
    end

    // One clock: apply the square pops seen at the edge, then redrive squares and reader.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int sq = 0; sq < NSQ; sq++) begin
            if (rd_snap[sq]) begin
                chk("sq pop legal", {62'd0, empty_snap[sq], ($countones(rd_snap) == 1)}, 64'd1);
                if (sq_q[sq].size() > 0) void'(sq_q[sq].pop_front());
            end
        end
        drive_sq();
        case (rd_mode)
            0: i_out_rden = 1'b0;
            1: i_out_rden = ($urandom_range(1) == 1) && !o_out_empty;
            2: i_out_rden = !o_out_empty;
            default: i_out_rden = i_out_rden;
        endcase
    endtask

    task automatic start_collection();
        i_out_rden = 1'b0;
        i_sq_done  = done_mask;
        build_expected();
        drive_sq();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int bound);
        int c;
        c = 0;
        while (!(o_done && o_out_empty && exp_q.size() == 0) && c < bound) begin
            tick();
            c++;
        end
        chk(name, c < bound, 1);
    endtask

    task automatic wait_count(input string name, input int n, input int bound);
        int c;
        c = 0;
        while (int'(o_out_count) != n && c < bound) begin
            tick();
            c++;
        end
        chk(name, c < bound, 1);
    endtask

    // Scoreboard: every accepted read of the column FIFO must match the next expected move.
    always @(negedge clk) begin
        if (i_reset && i_out_rden && !o_out_empty) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL out_data: got %0h with no word expected", o_out_data);
            end else begin
                chk("out_data", o_out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        i_reset = 1'b0; i_start = 1'b0; xpos = 3'd3; i_sq_done = '0;
        i_sq_empty = '1; i_sq_data = '0; i_out_rden = 1'b0;
        stall_pct = 0; rd_mode = 0; done_mask = '1; exp_total = 0;
        for (int sq = 0; sq < NSQ; sq++) sq_q[sq].delete();
        #23;
        chk("reset sq_rden", o_sq_rden, 0);
        chk("reset out_empty", o_out_empty, 1);
        chk("reset out_count", o_out_count, 0);
        chk("reset moves_total", o_moves_total, 0);
        chk("reset done", o_done, 0);
        chk("reset err", o_err, 0);
        @(posedge clk); #1 i_reset = 1'b1;
        tick();

        // Empty lists: eight SCAN/DRAIN pairs plus the final SCAN into DONE.
        for (int sq = 0; sq < NSQ; sq++) load_list(sq, 0);
        done_mask = '1;
        start_collection();
        begin
            int c;
            c = 0;
            while (!o_done && c < 100) begin tick(); c++; end
            chk("empty done latency", c, 17);
        end
        chk("empty moves_total", o_moves_total, 0);
        chk("empty out_empty", o_out_empty, 1);
        chk("empty err", o_err, 0);

        // Reading an empty column FIFO raises a sticky error.
        rd_mode = 3; i_out_rden = 1'b1;
        tick();
        i_out_rden = 1'b0;
        chk("underflow err", o_err, 1);
        tick(); tick(); tick();
        chk("underflow err sticky", o_err, 1);

        // Priority: square 5 (A,B) before square 2 (C).
        rd_mode = 0;
        for (int sq = 0; sq < NSQ; sq++) load_list(sq, 0);
        load_list(5, 2);
        load_list(2, 1);
        start_collection();
        chk("start clears err", o_err, 0);
        begin
            int c;
            c = 0;
            while (!o_done && c < 100) begin tick(); c++; end
            chk("prio done timeout", c < 100, 1);
        end
        chk("prio out_count", o_out_count, 3);
        chk("prio moves_total", o_moves_total, 3);
        rd_mode = 2;
        wait_drained("prio drain timeout", 50);
        chk("prio done holds", o_done, 1);

        // Back-pressure with a 4-deep FIFO, then push+pop while full.
        rd_mode = 0;
        for (int sq = 0; sq < NSQ; sq++) load_list(sq, 0);
        load_list(7, 6);
        start_collection();
        for (int k = 0; k < 20; k++) tick();
        @(negedge clk);
        chk("bp out_count", o_out_count, DEPTH);
        chk("bp sq_rden low", o_sq_rden, 0);
        chk("bp not done", o_done, 0);
        tick();
        rd_mode = 3; i_out_rden = 1'b1;
        @(negedge clk);
        chk("full rd+wr sq_rden", o_sq_rden, 8'h80);
        tick();
        i_out_rden = 1'b0;
        chk("full rd+wr count", o_out_count, DEPTH);
        rd_mode = 2;
        wait_drained("bp drain timeout", 100);
        chk("bp moves_total", o_moves_total, 6);

        // Restart after square 7 is already drained and square 6 is mid-list.
        rd_mode = 0;
        for (int sq = 0; sq < NSQ; sq++) load_list(sq, 0);
        load_list(6, 3);
        start_collection();
        wait_count("restart fill timeout", 3, 50);
        for (int sq = 0; sq < NSQ; sq++) load_list(sq, 0);
        load_list(7, 1);
        load_list(3, 1);
        start_collection();
        chk("restart out_count", o_out_count, 0);
        chk("restart out_empty", o_out_empty, 1);
        chk("restart moves_total", o_moves_total, 0);
        chk("restart done", o_done, 0);
        rd_mode = 2;
        wait_drained("restart drain timeout", 100);
        chk("restart moves_total end", o_moves_total, 2);

        // Dropping sq_done of the square being drained flags an error but draining continues.
        rd_mode = 0;
        for (int sq = 0; sq < NSQ; sq++) load_list(sq, 0);
        load_list(7, 2);
        start_collection();
        wait_count("drop fill timeout", 1, 50);
        chk("drop err before", o_err, 0);
        i_sq_done = 8'h7f;
        tick();
        i_sq_done = done_mask;
        chk("drop err set", o_err, 1);
        rd_mode = 2;
        wait_drained("drop drain timeout", 100);
        chk("drop moves_total", o_moves_total, 2);

        // Asynchronous reset in the middle of a drain.
        rd_mode = 0;
        for (int sq = 0; sq < NSQ; sq++) load_list(sq, 0);
        load_list(7, 3);
        start_collection();
        wait_count("reset fill timeout", 2, 50);
        #2 i_reset = 1'b0;
        #1;
        chk("arst sq_rden", o_sq_rden, 0);
        chk("arst out_empty", o_out_empty, 1);
        chk("arst out_count", o_out_count, 0);
        chk("arst moves_total", o_moves_total, 0);
        chk("arst done", o_done, 0);
        chk("arst err", o_err, 0);
        exp_q.delete();
        for (int sq = 0; sq < NSQ; sq++) sq_q[sq].delete();
        @(posedge clk); #1 i_reset = 1'b1;
        tick();

        // Randomised lists, stalls on the square side and a random reader.
        stall_pct = 25;
        rd_mode   = 1;
        for (int it = 0; it < 15; it++) begin
            xpos = 3'($urandom_range(7));
            for (int sq = 0; sq < NSQ; sq++) load_list(sq, $urandom_range(5));
            done_mask = '1;
            start_collection();
            wait_drained("rand drain timeout", 1000);
            chk("rand moves_total", o_moves_total, exp_total);
            chk("rand err", o_err, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/column_move_collector.md
Name: column_move_collector

Overview:
- Parametrised successor to the column move-gathering unit.
- Drains the per-square move FIFOs of one board column (NSQ squares) into one local column FIFO that the board-level arbiter reads. Each square's list is terminated by an END word.
- Adds configurable square count, move width and FIFO depth; a start/restart command; back-pressure on a full column FIFO; a collected-move counter; and an overflow/error flag.

Parameters:
- NSQ, 8, number of squares in the column (1..8).
- MOVE_W, 48, move word width. Must be a multiple of 6; each 6-bit field is one {x,y} square id.
- DEPTH, 64, column FIFO entries (power of 2, at least 2).
- CNT_W, 16, width of the collected-move counter.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse: begin a new collection.
- xpos, in, 3, column index of this unit.
- sq_done, in, NSQ, bit i high means square i has finished generating its list.
- sq_empty, in, NSQ, bit i high means square i's FIFO is empty.
- sq_data, in, NSQ*MOVE_W, show-ahead head word of each square FIFO; square i occupies [i*MOVE_W +: MOVE_W].
- sq_rden, out, NSQ, one-hot pop strobe to the square FIFOs.
- out_rden, in, 1, pop strobe for the column FIFO.
- out_data, out, MOVE_W, show-ahead head of the column FIFO.
- out_empty, out, 1, column FIFO empty.
- out_count, out, log2(DEPTH)+1, column FIFO occupancy.
- moves_total, out, CNT_W, non-END words collected since start; saturates at all-ones.
- done, out, 1, every square's list has been drained.
- err, out, 1, sticky error: out_rden while empty, or sq_done dropped mid-drain.

Behaviour:
- Reset values: sq_rden=0, out_empty=1, out_count=0, moves_total=0, done=0, err=0. FSM enters IDLE and all moved flags clear.
- END word for square i: every 6-bit field equals {xpos, i[2:0]}, i.e. a self-to-self move.
- FSM states:
  - IDLE: wait for start.
  - SCAN: pick the next square.
  - DRAIN: move words from the selected square.
  - DONE: collection complete.
- start, valid in any state, takes effect next cycle: clears moved flags, flushes the column FIFO (count=0), clears moves_total and err, and moves the FSM to SCAN. start has priority over every other event in that cycle.
- SCAN: select the highest index i with sq_done[i]=1 and moved[i]=0, latch it as ptr and go to DRAIN. If all NSQ moved flags are set, go to DONE. Otherwise stay in SCAN. SCAN takes 1 cycle per selection.
- DRAIN on ptr: pop (sq_rden[ptr]=1) only when sq_empty[ptr]=0 and the current word is either END or the column FIFO can accept a write.
  - Non-END word: written into the column FIFO in the same cycle; moves_total increments.
  - END word: popped and discarded; moved[ptr] is set; next state is SCAN.
  - sq_empty[ptr]=1: stall in DRAIN with no pop.
  - Sustained throughput: 1 word per cycle.
- Column FIFO "can accept": count<DEPTH, or (count==DEPTH and out_rden and not empty), i.e. simultaneous pop and push when full is allowed.
- Column FIFO operation: push and pop in the same cycle leave count unchanged. out_data is valid whenever out_empty=0. Pointers wrap modulo DEPTH.
- out_rden while out_empty=1: ignored, and err is set.
- sq_done[ptr] dropping to 0 during DRAIN: err is set; draining continues.
- DONE: done=1 and holds until start or reset. The column FIFO remains readable.
- Reset assertion mid-operation: immediately returns every output to its reset value; FIFO contents are lost.

Test Plan:
- Empty lists, NSQ=8, xpos=3: raise all sq_done with each FIFO holding only its END word -> 8 SCAN/DRAIN pairs (squares 7 down to 0); done rises about 17 cycles after start; moves_total=0; out_empty=1.
- Priority and order: square 5 holds moves A,B,END; square 2 holds C,END; both done together -> out_data reads A,B,C in that order; moves_total=3; done=1.
- Back-pressure, DEPTH=4: square 7 holds 6 moves + END; out_rden low -> out_count stops at 4 and sq_rden stays low. Then hold out_rden high -> all 6 moves delivered in order, no loss or duplication.
- Full with simultaneous read: count=DEPTH, a square supplies a word, out_rden=1 in the same cycle -> push and pop both occur; count stays at DEPTH.
- Restart and reset: start pulsed mid-drain with count=3 -> next cycle count=0, moved flags clear, FSM in SCAN. reset held low mid-drain -> all outputs return to reset values immediately, independent of clk.
- Errors: out_rden while empty -> err=1 and stays set until start. sq_done[ptr] dropped during DRAIN -> err=1.
